aes_inv_subbytes_stage: RTL

//  Iterative InvSubBytes stage of the AES decryption datapath. Accepts a 128-bit state

---
 rtl/aes_pkg.sv | 28 ++
 rtl/aes_inv_sbox.sv | 9 +
 rtl/aes_inv_subbytes_stage.sv | 65 ++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES datapath types, the inverse S-box table and the byte-order helper.
package aes_pkg;
  typedef logic [127:0] aes_state_t;
  typedef logic [7:0] aes_byte_t;
  typedef enum logic [1:0] {IDLE, SUB, DONE} sub_st_e;
  localparam aes_byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
  // byte 0 is the most significant byte of the state word
  function automatic aes_byte_t get_byte(aes_state_t s, logic [3:0] idx);
    return s[{~idx, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: combinational inverse S-box byte lookup.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  aes_byte_t in_byte,
  output aes_byte_t out_byte
);
  assign out_byte = INV_SBOX[in_byte];
endmodule

// File: rtl/aes_inv_subbytes_stage.sv
// aes_inv_subbytes_stage: iterative InvSubBytes, BPC bytes per cycle, valid/ready on both sides.
module aes_inv_subbytes_stage
  import aes_pkg::*;
#(
  parameter int BPC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_state_t in_state,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_state_t out_state,
  output logic       busy
);
  localparam int NCYC = 16 / BPC;
  localparam int CW = $clog2(NCYC) + 1;
  sub_st_e st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  aes_state_t state_q, state_d;
  aes_byte_t sb_in [BPC];
  aes_byte_t sb_out [BPC];
  for (genvar g = 0; g < BPC; g++) begin : gen_sbox
    assign sb_in[g] = get_byte(state_q, 4'(cnt_q * BPC + g));
    aes_inv_sbox u_sbox (.in_byte(sb_in[g]), .out_byte(sb_out[g]));
  end
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    state_d = state_q;
    if (clear) st_d = IDLE;
    else
      case (st_q)
        IDLE: if (in_valid) begin
          state_d = in_state;
          cnt_d = '0;
          st_d = SUB;
        end
        SUB: begin
          for (int k = 0; k < BPC; k++) state_d[{~4'(cnt_q * BPC + k), 3'b000} +: 8] = sb_out[k];
          cnt_d = cnt_q + 1'b1;
          st_d = (cnt_q == CW'(NCYC - 1)) ? DONE : SUB;
        end
        DONE: st_d = out_ready ? IDLE : DONE;
        default: st_d = IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      state_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
    end
  end
  assign in_ready = st_q == IDLE;
  assign out_valid = st_q == DONE;
  assign busy = st_q != IDLE;
  assign out_state = state_q;
endmodule
